// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
//   owner_t : who a returning read belongs to (none / CPU / DMA)
//   state_t : arbiter FSM state, the port that was granted last cycle
// Default widths fit a 64K x 8 RAM.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// Saturating counter that tracks consecutive locked DMA grants.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   inc      : count one more locked grant; holds once at MAX
//   clr      : return to zero; takes priority over inc
//   sat      : high while the count equals MAX
module mem_arb_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the CPU core and a DMA engine.
// One requester wins per cycle. Its command goes to the RAM. Reads are tagged,
// so the RAM data that comes back a cycle later is strobed to the right port.
//
// Build option: MEM_ARB_ROUND_ROBIN_EN alternates the winner when both ports
// request at once. Without it the CPU always wins.
//
// Handshake: a port raises req with we/addr/wdata and holds them steady until
// it sees gnt high in the same cycle. The access is issued in that gnt cycle.
// For a read, rvalid is high for exactly the following cycle, and rdata is
// valid only while rvalid is high. A port may drop req before it is granted.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   cpu_* / dma_*        requester ports (req, we, addr, wdata, gnt, rdata, rvalid)
//   dma_lock             DMA asks to keep ownership back-to-back
//   mem_we/addr/din      RAM command, zero when nobody is granted
//   mem_dout             RAM read data, valid one cycle after the address
//   dbg_state            current FSM state (last granted port)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    input  logic              dma_lock,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output state_t            dbg_state
);

    state_t state;
    owner_t rd_owner;
    logic   burst_sat;
    logic   burst_inc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t rr_last;
`endif

    // Priority order: an unfinished locked burst first, then the forced CPU
    // yield once the burst is full, then the contention policy, then a lone
    // requester.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!RST) begin
            if ((state == ST_DMA) && dma_req && dma_lock && !burst_sat) begin
                dma_gnt = 1'b1;
            end else if (burst_sat && cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (cpu_req && dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (rr_last == OWN_CPU) begin
                    dma_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
`else
                cpu_gnt = 1'b1;
`endif
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (cpu_gnt) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_din  = dma_wdata;
        end
    end

    // Any grant that is not a locked DMA grant ends the burst. An idle cycle
    // also ends it. Once the count is full, a lone locked DMA keeps winning
    // and the count stays full.
    assign burst_inc = dma_gnt && dma_lock;

    mem_arb_burst_ctr #(
        .MAX (MAX_BURST)
    ) u_burst_ctr (
        .CLK (CLK),
        .RST (RST),
        .inc (burst_inc),
        .clr (!burst_inc),
        .sat (burst_sat)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            rd_owner <= OWN_NONE;
        end else begin
            if (cpu_gnt) begin
                state <= ST_CPU;
            end else if (dma_gnt) begin
                state <= ST_DMA;
            end else begin
                state <= ST_IDLE;
            end

            if (cpu_gnt && !cpu_we) begin
                rd_owner <= OWN_CPU;
            end else if (dma_gnt && !dma_we) begin
                rd_owner <= OWN_DMA;
            end else begin
                rd_owner <= OWN_NONE;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_last <= OWN_CPU;
        end else if (cpu_gnt) begin
            rr_last <= OWN_CPU;
        end else if (dma_gnt) begin
            rr_last <= OWN_DMA;
        end
    end
`endif

    // A read still in flight when reset arrives is dropped, including the
    // cycle that reset is held.
    assign cpu_rvalid = (rd_owner == OWN_CPU) && !RST;
    assign dma_rvalid = (rd_owner == OWN_DMA) && !RST;
    assign cpu_rdata  = mem_dout;
    assign dma_rdata  = mem_dout;
    assign dbg_state  = state;

endmodule
